// File: rtl/execute_muldiv_unit_pkg.sv
// Shared encodings for the execute-stage M-extension unit:
// funct7/funct3 constants, FSM states and divide control bundle.
package execute_muldiv_unit_pkg;

   localparam logic [6:0] MEXT_FUNCT7 = 7'b0000001;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic want_rem;
      logic q_neg;
      logic r_neg;
      logic early;
   } div_ctl_t;

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle; done stays high until the next start.
module muldiv_div_iter
   import execute_muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] dvs;
   logic [CW-1:0]   cnt;
   logic            run;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   assign shifted = {remainder, quotient[XLEN-1]};
   assign diff    = shifted - {1'b0, dvs};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quotient  <= '0;
         remainder <= '0;
         dvs       <= '0;
         cnt       <= '0;
         run       <= 1'b0;
         done      <= 1'b0;
      end else if (kill) begin
         run  <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         quotient  <= dividend;
         remainder <= '0;
         dvs       <= divisor;
         cnt       <= '0;
         run       <= 1'b1;
         done      <= 1'b0;
      end else if (run) begin
         if (diff[XLEN]) begin
            remainder <= shifted[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], 1'b0};
         end else begin
            remainder <= diff[XLEN-1:0];
            quotient  <= {quotient[XLEN-2:0], 1'b1};
         end
         cnt <= cnt + CW'(1);
         if (cnt == CW'(XLEN - 1)) begin
            run  <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/execute_muldiv_unit.sv
// RV M-extension multiply/divide unit for the execute stage.
// Define MULDIV_OPERAND_CACHE_EN to reuse the last divide's results.
module execute_muldiv_unit
   import execute_muldiv_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 2,
   parameter int RD_W        = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [RD_W-1:0] in_rd_index,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [RD_W-1:0] out_rd_index,
   output logic            busy
);

   localparam int CW = 2;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state;
   funct3_e         op_q;
   div_ctl_t        ctl;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [RD_W-1:0] rd_q;
   logic [CW-1:0]   mul_cnt;

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);

   logic            accept;
   logic            d_sgn;
   logic            neg_a;
   logic            neg_b;
   logic            div0;
   logic            ovf;
   logic            early;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic [XLEN-1:0] early_res;

   assign accept = in_valid & in_ready & !flush;
   assign d_sgn  = !in_funct3[0];
   assign neg_a  = d_sgn & in_rs1[XLEN-1];
   assign neg_b  = d_sgn & in_rs2[XLEN-1];
   assign mag_a  = neg_a ? -in_rs1 : in_rs1;
   assign mag_b  = neg_b ? -in_rs2 : in_rs2;
   assign div0   = (in_rs2 == '0);
   assign ovf    = d_sgn & (in_rs1 == MIN) & (in_rs2 == '1);

`ifdef MULDIV_OPERAND_CACHE_EN
   logic            c_valid;
   logic            c_sgn;
   logic            sgn_q;
   logic [XLEN-1:0] c_rs1;
   logic [XLEN-1:0] c_rs2;
   logic [XLEN-1:0] c_quo;
   logic [XLEN-1:0] c_rem;
   logic            hit;

   assign hit = c_valid & (c_sgn == d_sgn)
              & (c_rs1 == in_rs1) & (c_rs2 == in_rs2);
`endif

   // Results known at accept; these skip the iterative divider.
   always_comb begin
      early     = 1'b1;
      early_res = '0;
      unique case (1'b1)
         div0: early_res = in_funct3[1] ? in_rs1 : '1;
         ovf:  early_res = in_funct3[1] ? '0 : MIN;
`ifdef MULDIV_OPERAND_CACHE_EN
         hit:  early_res = in_funct3[1] ? c_rem : c_quo;
`endif
         default: early = 1'b0;
      endcase
   end

   logic            div_start;
   logic            div_done;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

   assign div_start = accept & in_funct3[2] & !early;

   muldiv_div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .kill      (flush),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   assign quo_fix = ctl.q_neg ? -quo : quo;
   assign rem_fix = ctl.r_neg ? -rem : rem;

   logic              a_sgn;
   logic              b_sgn;
   logic              mul_hi;
   logic [2*XLEN-1:0] a_ext;
   logic [2*XLEN-1:0] b_ext;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res;

   always_comb begin
      a_sgn  = 1'b0;
      b_sgn  = 1'b0;
      mul_hi = 1'b1;
      unique case (op_q)
         F3_MULH: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         F3_MULHSU: a_sgn = 1'b1;
         F3_MULHU:  mul_hi = 1'b1;
         default:   mul_hi = 1'b0;
      endcase
   end

   // Low 2*XLEN bits of the extended product are exact for all forms.
   assign a_ext   = {{XLEN{a_sgn & rs1_q[XLEN-1]}}, rs1_q};
   assign b_ext   = {{XLEN{b_sgn & rs2_q[XLEN-1]}}, rs2_q};
   assign prod    = a_ext * b_ext;
   assign mul_res = mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         op_q         <= F3_MUL;
         ctl          <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         mul_cnt      <= '0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_rd_index <= '0;
`ifdef MULDIV_OPERAND_CACHE_EN
         c_valid <= 1'b0;
         c_sgn   <= 1'b0;
         sgn_q   <= 1'b0;
         c_rs1   <= '0;
         c_rs2   <= '0;
         c_quo   <= '0;
         c_rem   <= '0;
`endif
      end else if (flush) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: if (in_valid) begin
               op_q    <= funct3_e'(in_funct3);
               rs1_q   <= in_rs1;
               rs2_q   <= in_rs2;
               rd_q    <= in_rd_index;
               mul_cnt <= '0;
               ctl     <= '{want_rem: in_funct3[1],
                            q_neg:    neg_a ^ neg_b,
                            r_neg:    neg_a,
                            early:    early};
`ifdef MULDIV_OPERAND_CACHE_EN
               sgn_q <= d_sgn;
`endif
               if (!in_funct3[2]) begin
                  state <= ST_MUL;
               end else if (early) begin
                  out_result <= early_res;
                  state      <= ST_FIX;
               end else begin
                  state <= ST_DIV;
               end
            end
            ST_MUL: begin
               if (mul_cnt == CW'(MUL_LATENCY - 1)) begin
                  out_result   <= mul_res;
                  out_rd_index <= rd_q;
                  out_valid    <= 1'b1;
                  state        <= ST_DONE;
               end else begin
                  mul_cnt <= mul_cnt + CW'(1);
               end
            end
            ST_DIV: if (div_done) state <= ST_FIX;
            ST_FIX: begin
               if (!ctl.early)
                  out_result <= ctl.want_rem ? rem_fix : quo_fix;
               out_rd_index <= rd_q;
               out_valid    <= 1'b1;
               state        <= ST_DONE;
`ifdef MULDIV_OPERAND_CACHE_EN
               if (!ctl.early) begin
                  c_valid <= 1'b1;
                  c_sgn   <= sgn_q;
                  c_rs1   <= rs1_q;
                  c_rs2   <= rs2_q;
                  c_quo   <= quo_fix;
                  c_rem   <= rem_fix;
               end
`endif
            end
            ST_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit (XLEN=32, MUL_LATENCY=2).
// Cache-hit latency follows MULDIV_OPERAND_CACHE_EN.
module tb_execute_muldiv_unit;
   import execute_muldiv_unit_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 34;
   localparam int SP_LAT  = 1;
`ifdef MULDIV_OPERAND_CACHE_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 34;
`endif

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_funct3;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_rd_index;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd_index;
   logic        busy;

   exp_t sb[$];
   exp_t me;
   int   n_chk  = 0;
   int   n_err  = 0;
   int   cyc    = 0;
   int   n_rise = 0;
   logic vprev  = 1'b0;

   execute_muldiv_unit #(
      .XLEN(32), .MUL_LATENCY(2), .RD_W(5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_funct3    (in_funct3),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_rd_index  (in_rd_index),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_rd_index (out_rd_index),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         vprev = 1'b0;
      end else begin
         if (out_valid && !vprev) begin
            n_rise++;
            if (sb.size() == 0) begin
               check("spurious_valid", out_valid, 0);
            end else begin
               me = sb.pop_front();
               check("result", out_result, me.res);
               check("rd", out_rd_index, me.rd);
               check("latency", cyc - me.acc, me.lat);
            end
         end
         vprev = out_valid;
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] res, input int lat,
                        input bit track);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("accept_ready", in_ready, 1);
      in_valid    = 1'b1;
      in_funct3   = f3;
      in_rs1      = a;
      in_rs2      = b;
      in_rd_index = rd;
      if (track) sb.push_back('{res: res, rd: rd, lat: lat, acc: cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || !in_ready) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", t < 100, 1);
   endtask

   task automatic run(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic [31:0] res, input int lat);
      issue(f3, a, b, rd, res, lat, 1'b1);
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] p;
      logic [31:0] a;
      logic [31:0] b;
      int          t;
      int          n0;

      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd_index = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_result", out_result, 0);
      check("rst_rd", out_rd_index, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", in_ready, 1);

      issue(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, MUL_LAT, 1'b1);
      check("busy_c0", busy, 1);
      @(negedge clk); check("busy_c1", busy, 1);
      @(negedge clk); check("busy_c2", busy, 1);
      @(negedge clk); check("busy_c3", busy, 0);
      drain();

      run(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, MUL_LAT);
      run(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, MUL_LAT);
      run(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, MUL_LAT);
      run(F3_DIV,  32'hFFFFFFF9, 32'd2, 5'd9,  32'hFFFFFFFD, DIV_LAT);
      run(F3_REM,  32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, HIT_LAT);
      run(F3_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, DIV_LAT);
      run(F3_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFFFFFF, SP_LAT);
      run(F3_REM,  32'd5, 32'd0, 5'd13, 32'd5, SP_LAT);
      run(F3_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, SP_LAT);
      run(F3_REM,  32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, SP_LAT);

      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         p = {32'd0, a} * {32'd0, b};
         run(F3_MUL,   a, b, 5'(i), p[31:0], MUL_LAT);
         run(F3_MULHU, a, b, 5'(i + 1), p[63:32], MUL_LAT);
         b = $urandom_range(1, 32'h0000FFFF);
         run(F3_DIVU, a, b, 5'(i + 2), a / b, DIV_LAT);
         run(F3_REMU, a, b, 5'(i + 3), a % b, HIT_LAT);
      end

      out_ready = 1'b0;
      issue(F3_MUL, 32'd3, 32'd4, 5'd9, 32'd12, MUL_LAT, 1'b1);
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("bp_wait", out_valid, 1);
      for (int i = 0; i < 4; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_result", out_result, 12);
         check("bp_rd", out_rd_index, 9);
         check("bp_in_ready", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", in_ready, 1);
      check("bp_release_valid", out_valid, 0);

      n0 = n_rise;
      issue(F3_DIV, 32'd100, 32'd7, 5'd3, 32'd0, 0, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ready", in_ready, 1);
      check("flush_busy", busy, 0);
      repeat (40) @(negedge clk);
      check("flush_no_valid", n_rise, n0);

      in_valid = 1'b1; in_funct3 = F3_MUL; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("idle_flush_ready", in_ready, 1);
      check("idle_flush_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("idle_flush_no_valid", n_rise, n0);

      run(F3_DIV,  32'd100, 32'd7, 5'd20, 32'd14, DIV_LAT);
      run(F3_REM,  32'd100, 32'd7, 5'd21, 32'd2, HIT_LAT);
      run(F3_DIVU, 32'd100, 32'd7, 5'd22, 32'd14, DIV_LAT);

      issue(F3_MUL, 32'd5, 32'd6, 5'd17, 32'd0, 0, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_result", out_result, 0);
      check("rst_mid_rd", out_rd_index, 0);
      check("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", in_ready, 1);
      n0 = n_rise;
      repeat (5) @(negedge clk);
      check("rst_mid_no_valid", n_rise, n0);

      run(F3_REM, 32'd100, 32'd7, 5'd23, 32'd2, DIV_LAT);

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Parametrised RV M-extension multiply/divide unit for the execute stage; sits beside the integer ALU.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per handshake and computes it over multiple cycles (pipelined-latency multiply, radix-2 restoring divide).
- Drives a busy/stall indication so decode holds, and returns the result with its rd index for the mem-stage pipeline register.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LATENCY, 2, cycles from accept to out_valid for multiplies; legal range 1..4.
- RD_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of the in-flight operation (branch taken in execute).
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; equals (state == IDLE).
- in_funct3  in  3  M-extension funct3 (000 MUL … 111 REMU).
- in_rs1  in  XLEN  forwarded rs1 value.
- in_rs2  in  XLEN  forwarded rs2 value.
- in_rd_index  in  RD_W  destination register.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes result.
- out_result  out  XLEN  result.
- out_rd_index  out  RD_W  destination of result.
- busy  out  1  operation accepted and not yet consumed (state != IDLE); stall request to decode.

Behaviour:
- Reset (rst low, async):
  - state = IDLE.
  - out_valid = 0, out_result = 0, out_rd_index = 0, busy = 0; in_ready = 1 after release.
  - All internal counters and registers are cleared.
  - Reset mid-operation abandons the operation; no result is produced.
- Accept: rising edge with in_valid & in_ready & !flush latches funct3, operands and rd. The accept edge is cycle 0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE → MUL on accept of funct3[2] = 0.
  - IDLE → DIV on accept of funct3[2] = 1.
  - IDLE → DONE on a divide special case.
  - MUL → DONE when the counter reaches MUL_LATENCY-1.
  - DIV → FIX after XLEN iterations.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
- Multiply:
  - Operands are extended to XLEN+1 bits: signed for MULH (both operands), MULHSU (rs1 only); zero-extended otherwise.
  - The 2·XLEN+2-bit product is computed.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - out_valid rises at cycle MUL_LATENCY.
- Divide:
  - Signed ops take operand magnitudes; XLEN restoring iterations, one quotient bit per cycle.
  - FIX applies signs: quotient negated if signs differ; remainder takes the dividend's sign.
  - out_valid rises at cycle XLEN+2.
- Divide special cases (out_valid at cycle 1):
  - Divisor = 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = MIN, divisor = -1): quotient = MIN; remainder = 0.
- Output hold: in DONE, out_valid, out_result and out_rd_index stay stable until out_ready. out_valid & out_ready returns to IDLE, so in_ready = 1 on the next cycle. There is no back-to-back accept in the consume cycle.
- Flush:
  - In any non-IDLE state: next state IDLE, out_valid deasserted next cycle, result discarded.
  - Flush in IDLE with in_valid: no accept.
  - Flush has priority over out_ready and over completion.

Optional Feature:
- Macro: MULDIV_OPERAND_CACHE_EN.
- With the macro defined:
  - On every normal divide completion, the unit stores rs1, rs2, signedness, quotient and remainder.
  - A later DIV/DIVU/REM/REMU with equal operands and signedness goes IDLE → DONE in 1 cycle (out_valid at cycle 1), selecting the quotient or remainder as required.
  - The cache is cleared by reset and not by flush.
  - A flushed divide does not update the cache.
- Without the macro: no cache registers; every divide takes the full latency.

Decomposition:
- common.vh gains:
  - the M-extension funct7 constant (0000001);
  - the eight funct3 encodings;
  - the FSM state encodings.
- One sub-module: muldiv_div_iter. It holds the restoring-divider datapath (remainder/quotient shift registers, iteration counter, start/done) and is parametrised by XLEN.
- Multiply, sign fix-up, special-case detection, the cache and the FSM stay in execute_muldiv_unit.

Test Plan (XLEN=32, MUL_LATENCY=2, out_ready=1 unless stated):
- MUL 7 × 0xFFFFFFFD (-3), rd=5 → out_result 0xFFFFFFEB, out_rd_index 5, out_valid at cycle 2, busy high cycles 0–2.
- rs1=rs2=0xFFFFFFFF → MULHU returns 0xFFFFFFFE; MULH returns 0x00000000; MULHSU returns 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD at cycle 34; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0; all at cycle 1.
- Backpressure and flush:
  - out_ready low for 4 cycles after out_valid → result and rd stay stable, in_ready stays 0.
  - flush at divide iteration 10 → out_valid never asserts; in_ready = 1 next cycle.
  - Async reset low mid-MUL → all outputs 0 immediately.
- Cache, with DIV 100/7 followed by REM 100/7:
  - with MULDIV_OPERAND_CACHE_EN: results 14 then 2; the REM returns at cycle 1;
  - without the macro: the REM returns at cycle 34.
